dmem_seq_ctrl: RTL and testbench

- Memory-stage sequencer for the sequential Y86-64 core.
- Decodes icode into read, write or no-op, and range-checks the 8-byte access.
- Drives a single-port, variable-latency data memory over a req/ack handshake, then returns valM and dmem_error with a one-cycle done pulse.
- Sits between the execute stage and the data memory; the core stalls while busy is high.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/dmem_decode.sv | 54 +++++
 rtl/dmem_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_dmem_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the memory-stage sequencer states.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/dmem_decode.sv
// Combinational memory-stage decode: access type, address, write data and 8-byte range check.
module dmem_decode
   import y86_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic [3:0]  icode,
   input  logic [63:0] valA,
   input  logic [63:0] valE,
   input  logic [63:0] valP,
   output logic        is_rd,
   output logic        is_wr,
   output logic [63:0] addr,
   output logic [63:0] wdata,
   output logic        range_err
);

   // Highest legal start address of an 8-byte access; unsigned compare, no wrap.
   localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES) - 64'd8;

   always_comb begin
      is_rd = 1'b0;
      is_wr = 1'b0;
      addr  = 64'd0;
      wdata = 64'd0;
      case (icode)
         I_RMMOVQ, I_PUSHQ: begin
            is_wr = 1'b1;
            addr  = valE;
            wdata = valA;
         end
         I_CALL: begin
            is_wr = 1'b1;
            addr  = valE;
            wdata = valP;
         end
         I_MRMOVQ: begin
            is_rd = 1'b1;
            addr  = valE;
         end
         I_RET, I_POPQ: begin
            is_rd = 1'b1;
            addr  = valA;
         end
         default: begin
            is_rd = 1'b0;
            is_wr = 1'b0;
         end
      endcase
   end

   assign range_err = (is_rd | is_wr) & (addr > MAX_ADDR);

endmodule

// File: rtl/dmem_seq_ctrl.sv
// Memory-stage sequencer: launches one data-memory access per start over a req/ack
// handshake with timeout, and reports valM / dmem_error with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// REQ   | mem_req high, address/data held, waiting for mem_ack or timeout
// DONE  | done pulse for one cycle, results valid
module dmem_seq_ctrl
   import y86_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic [63:0] valA,
   input  logic [63:0] valE,
   input  logic [63:0] valP,
   output logic        busy,
   output logic        done,
   output logic [63:0] valM,
   output logic        dmem_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int          CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] TO_SAT  = CW'(TIMEOUT);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   valm_q, valm_d;
   logic          err_q, err_d;
   logic          we_q, we_d;
   logic [63:0]   addr_q, addr_d;
   logic [63:0]   wdata_q, wdata_d;

   logic          dec_rd, dec_wr, dec_range_err;
   logic [63:0]   dec_addr, dec_wdata;

   dmem_decode #(
      .MEM_BYTES (MEM_BYTES)
   ) u_decode (
      .icode     (icode),
      .valA      (valA),
      .valE      (valE),
      .valP      (valP),
      .is_rd     (dec_rd),
      .is_wr     (dec_wr),
      .addr      (dec_addr),
      .wdata     (dec_wdata),
      .range_err (dec_range_err)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         valm_q  <= 64'd0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 64'd0;
         wdata_q <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valm_q  <= valm_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      valm_d  = valm_q;
      err_d   = err_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               valm_d = 64'd0;
               err_d  = 1'b0;
               if (!dec_rd && !dec_wr) begin
                  state_d = ST_DONE;
               end else if (dec_range_err) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_REQ;
                  addr_d  = dec_addr;
                  we_d    = dec_wr;
                  wdata_d = dec_wdata;
                  cnt_d   = '0;
               end
            end
         end
         ST_REQ: begin
            // An ack in the final allowed cycle takes priority over the timeout.
            if (mem_ack) begin
               state_d = ST_DONE;
               valm_d  = we_q ? 64'd0 : mem_rdata;
            end else if (cnt_q >= TO_LAST) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
               valm_d  = 64'd0;
            end else if (cnt_q != TO_SAT) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign mem_req    = (state_q == ST_REQ);
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign valM       = valm_q;
   assign dmem_error = err_q;

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Self-checking bench for dmem_seq_ctrl: directed vector table, held-start and reset
// corner sequences, then randomized operations against a transaction-level model.
module tb_dmem_seq_ctrl;
   import y86_pkg::*;

   localparam int unsigned MEM_BYTES = 1024;
   localparam int unsigned TIMEOUT   = 16;
   localparam int          NEVER     = 1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  icode;
   logic [63:0] valA, valE, valP;
   logic        busy, done, dmem_error;
   logic [63:0] valM;
   logic        mem_req, mem_we;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   dmem_seq_ctrl #(
      .MEM_BYTES (MEM_BYTES),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .icode      (icode),
      .valA       (valA),
      .valE       (valE),
      .valP       (valP),
      .busy       (busy),
      .done       (done),
      .valM       (valM),
      .dmem_error (dmem_error),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [63:0] mem_words [logic [63:0]];

   function automatic logic [63:0] fill_pat(input logic [63:0] a);
      return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
   endfunction

   function automatic logic [63:0] mem_rd(input logic [63:0] a);
      return mem_words.exists(a) ? mem_words[a] : fill_pat(a);
   endfunction

   typedef struct packed {
      logic [3:0]  icode;
      logic [63:0] valA;
      logic [63:0] valE;
      logic [63:0] valP;
      int          delay;
      bit          exp_req;
      bit          exp_we;
      logic [63:0] exp_addr;
      logic [63:0] exp_wdata;
      logic [63:0] exp_valM;
      bit          exp_err;
      int          exp_lat;
      int          exp_reqcyc;
   } vec_t;

   // Transaction-level model: what one operation should do, given the ack delay
   // (number of REQ cycles before the one carrying the ack).
   function automatic vec_t ref_vec(input logic [3:0] ic, input logic [63:0] a,
                                    input logic [63:0] e, input logic [63:0] p,
                                    input int delay);
      vec_t v;
      bit rd, wr, served;
      logic [63:0] ad, wd;
      v = '0;
      v.icode = ic; v.valA = a; v.valE = e; v.valP = p; v.delay = delay;
      rd = 0; wr = 0; ad = 0; wd = 0;
      if (ic == 4'h4 || ic == 4'hA) begin wr = 1; ad = e; wd = a; end
      else if (ic == 4'h8)          begin wr = 1; ad = e; wd = p; end
      else if (ic == 4'h5)          begin rd = 1; ad = e; end
      else if (ic == 4'h9 || ic == 4'hB) begin rd = 1; ad = a; end
      if (!rd && !wr) begin
         v.exp_lat = 1;
      end else if (ad > 64'(MEM_BYTES) - 64'd8) begin
         v.exp_err = 1;
         v.exp_lat = 1;
      end else begin
         served       = (delay < int'(TIMEOUT));
         v.exp_req    = 1;
         v.exp_we     = wr;
         v.exp_addr   = ad;
         v.exp_wdata  = wd;
         v.exp_reqcyc = served ? delay + 1 : int'(TIMEOUT);
         v.exp_lat    = v.exp_reqcyc + 1;
         v.exp_err    = !served;
         v.exp_valM   = (served && rd) ? mem_rd(ad) : 64'd0;
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v, input string tag);
      int cyc, reqcyc;
      bit seen, hold_ok, busy_ok;
      logic [63:0] held_valM;
      logic        held_err;
      @(negedge clk);
      start = 1'b1; icode = v.icode; valA = v.valA; valE = v.valE; valP = v.valP;
      @(posedge clk); #1;
      start = 1'b0;
      icode = 4'($urandom); valA = {$urandom, $urandom}; valE = {$urandom, $urandom};
      valP = {$urandom, $urandom};
      cyc = 1; reqcyc = 0; seen = 0; hold_ok = 1; busy_ok = 1;
      while (cyc <= 40) begin
         if (done) begin seen = 1; break; end
         if (!busy) busy_ok = 0;
         if (mem_req) begin
            reqcyc++;
            if (mem_addr !== v.exp_addr || mem_we !== v.exp_we ||
                (v.exp_we && mem_wdata !== v.exp_wdata)) hold_ok = 0;
            if (reqcyc == v.delay + 1) begin
               mem_ack = 1'b1;
               if (mem_we) mem_words[mem_addr] = mem_wdata;
               else        mem_rdata = mem_rd(mem_addr);
            end
         end
         @(posedge clk); #1;
         mem_ack = 1'b0;
         mem_rdata = {$urandom, $urandom};
         cyc++;
      end
      chk({tag, " done_seen"}, 64'(seen), 64'd1);
      chk({tag, " latency"}, 64'(cyc), 64'(v.exp_lat));
      chk({tag, " req_cycles"}, 64'(reqcyc), 64'(v.exp_reqcyc));
      chk({tag, " req_fields_held"}, 64'(hold_ok), 64'd1);
      chk({tag, " busy_while_active"}, 64'(busy_ok & busy), 64'd1);
      chk({tag, " valM"}, valM, v.exp_valM);
      chk({tag, " dmem_error"}, 64'(dmem_error), 64'(v.exp_err));
      held_valM = valM; held_err = dmem_error;
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, 64'({done, busy}), 64'd0);
      chk({tag, " results_held"}, {valM[62:0] ^ held_valM[62:0], dmem_error ^ held_err}, 64'd0);
   endtask

   vec_t tbl [12];

   initial begin
      int dcount, reqs;
      bit dbl, req_seen, bad;
      vec_t v;
      logic [63:0] a, e;
      int delay;

      rst_n = 1'b0; start = 1'b0; icode = 4'h0; valA = 0; valE = 0; valP = 0;
      mem_rdata = 0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy), 0);
      chk("reset done", 64'(done), 0);
      chk("reset valM", valM, 0);
      chk("reset dmem_error", 64'(dmem_error), 0);
      chk("reset mem_req", 64'(mem_req), 0);
      chk("reset mem_we", 64'(mem_we), 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset mem_wdata", mem_wdata, 0);
      @(negedge clk); rst_n = 1'b1;

      //           icode  valA                    valE                    valP                    dly  req we addr    wdata                   valM                    err lat rc
      tbl[0]  = '{4'h4, 64'h48E9230AF28C4B74, 64'h2FF, 64'h1234, 2, 1, 1, 64'h2FF, 64'h48E9230AF28C4B74, 64'h0, 0, 4, 3};
      tbl[1]  = '{4'h8, 64'h0, 64'h374, 64'h9463197C93D8910A, 0, 1, 1, 64'h374, 64'h9463197C93D8910A, 64'h0, 0, 2, 1};
      tbl[2]  = '{4'h9, 64'h374, 64'h0941858AC02818FF, 64'h0, 1, 1, 0, 64'h374, 64'h0, 64'h9463197C93D8910A, 0, 3, 2};
      tbl[3]  = '{4'h5, 64'h0, 64'h3FC, 64'h0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 1, 1, 0};
      tbl[4]  = '{4'h5, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 1, 1, 0};
      tbl[5]  = '{4'hA, 64'h5555AAAA5555AAAA, 64'h100, 64'h0, NEVER, 1, 1, 64'h100, 64'h5555AAAA5555AAAA, 64'h0, 1, 17, 16};
      tbl[6]  = '{4'hA, 64'h6666123466661234, 64'h100, 64'h0, 15, 1, 1, 64'h100, 64'h6666123466661234, 64'h0, 0, 17, 16};
      tbl[7]  = '{4'h6, 64'h1, 64'h100, 64'h2, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 1, 0};
      tbl[8]  = '{4'h5, 64'h0, 64'h3F8, 64'h0, 0, 1, 0, 64'h3F8, 64'h0, fill_pat(64'h3F8), 0, 2, 1};
      tbl[9]  = '{4'hB, 64'h100, 64'h108, 64'h0, 4, 1, 0, 64'h100, 64'h0, 64'h6666123466661234, 0, 6, 5};
      tbl[10] = '{4'h9, 64'h3F9, 64'h0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 1, 1, 0};
      tbl[11] = '{4'h0, 64'h0, 64'h0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 0, 1, 0};
      for (int i = 0; i < 12; i++) run_op(tbl[i], $sformatf("vec%0d", i));

      // start held high on a no-op: accepted only from IDLE, one done per accept
      @(negedge clk); start = 1'b1; icode = 4'h6;
      dcount = 0; dbl = 0; req_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) begin
            dcount++;
            if (i > 0 && dcount > (i + 2) / 2) dbl = 1;
         end
         if (mem_req) req_seen = 1;
      end
      @(negedge clk); start = 1'b0;
      chk("held_noop done_count", 64'(dcount), 4);
      chk("held_noop no_double", 64'(dbl), 0);
      chk("held_noop no_req", 64'(req_seen), 0);
      @(posedge clk);

      // start held high on a call with immediate ack
      @(negedge clk); start = 1'b1; icode = 4'h8; valE = 64'h10; valP = 64'hCAFE;
      dcount = 0; reqs = 0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (done) dcount++;
         if (mem_req) begin reqs++; mem_ack = 1'b1; end
      end
      @(negedge clk); start = 1'b0; mem_ack = 1'b0;
      chk("held_call done_count", 64'(dcount), 3);
      chk("held_call req_count", 64'(reqs), 3);
      repeat (2) @(posedge clk);

      // reset while in REQ, then a late ack
      @(negedge clk); start = 1'b1; icode = 4'hA; valE = 64'h200; valA = 64'hDEAD;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #1; chk("midreset in_req", 64'(mem_req), 1);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midreset outputs", {busy, done, dmem_error, mem_req, mem_we}, 0);
      chk("midreset addr_data", mem_addr | mem_wdata | valM, 0);
      @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1;
      @(posedge clk); #1; mem_ack = 1'b0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (done || busy) bad = 1;
         @(posedge clk); #1;
      end
      chk("late_ack ignored", 64'(bad), 0);

      // randomized operations against the model
      for (int n = 0; n < 80; n++) begin
         a = 64'(8 * $urandom_range(0, 127));
         e = 64'(8 * $urandom_range(0, 127));
         if ($urandom_range(0, 7) == 0) e = 64'h3F9 + 64'($urandom_range(0, 300));
         if ($urandom_range(0, 9) == 0) a = 64'hFFFFFFFFFFFFFFF8 + 64'($urandom_range(0, 7));
         delay = ($urandom_range(0, 5) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 3));
         v = ref_vec(4'($urandom_range(0, 15)), a, e, {$urandom, $urandom}, delay);
         run_op(v, $sformatf("rnd%0d ic=%h", n, v.icode));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
